pll_cfg_sequencer: RTL and testbench
====================================

Name: pll_cfg_sequencer

Overview:
Drains the 104-bit PLL configuration FIFO that the Wishbone API slave fills (reg_pllf_data / reg_pllf_wr_en). For each entry it selects the target chain and shifts the 96-bit PLL word out over a 3-wire serial port. It then waits for the PLL to lock, with a timeout. Completion and lock-failure status are returned to the API slave for CPU readback.

Parameters:
CLK_DIV, 8, clk cycles per sck half-period (valid range 1..255)
SETTLE_CYC, 16, clk cycles with cs_n high after the shift, before lock sampling starts
LOCK_TIMEOUT, 4096, maximum clk cycles to wait for pll_lock (valid range 1..65535)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
pllf_empty  input  1  config FIFO empty
pllf_rd_en  output  1  config FIFO pop; data is valid on pllf_dout the following cycle
pllf_dout  input  104  FIFO entry: [7:0] chain id, [103:8] PLL word
pllf_flush  input  1  abort and flush request (driven from reg_pllf_rst)
pll_cs_n  output  1  serial chip select, active low
pll_sck  output  1  serial clock, idles low
pll_sdo  output  1  serial data, MSB first
pll_chain  output  8  chain select; latched per entry
pll_lock  input  1  PLL lock indication, synchronous to clk
busy  output  1  sequencer not IDLE
cfg_done  output  1  one-cycle pulse: entry configured and locked
lock_err  output  1  one-cycle pulse: lock timeout
err_cnt  output  8  lock-timeout count, saturates at 255

Behaviour:
- Reset values: pllf_rd_en=0, pll_cs_n=1, pll_sck=0, pll_sdo=0, pll_chain=0, busy=0, cfg_done=0, lock_err=0, err_cnt=0, state=IDLE.
- Clock and reset: one clock (clk). rst is synchronous and active-high.
- States: IDLE, POP, LOAD, SHIFT, SETTLE, WAIT_LOCK.
- busy = (state != IDLE). All outputs are registered.
- IDLE: if pllf_empty=0 and pllf_flush=0, go to POP. Otherwise stay in IDLE.
- POP: pllf_rd_en=1 for exactly one cycle, then go to LOAD.
- LOAD:
  - Capture pllf_dout[103:8] into a 96-bit shift register and pllf_dout[7:0] into pll_chain.
  - Go to SHIFT. pll_cs_n goes low and pll_sdo=bit 103 in the same registered update.
- SHIFT, per bit:
  - sck low for CLK_DIV cycles, then high for CLK_DIV cycles. The slave samples on the rising edge.
  - sdo advances to the next bit on the cycle sck returns low.
  - 96 bits take 96*2*CLK_DIV cycles.
  - After the last high phase: sck=0, cs_n=1, sdo=0, go to SETTLE.
- SETTLE: count SETTLE_CYC cycles, then go to WAIT_LOCK and clear the timeout counter.
- WAIT_LOCK:
  - pll_lock=1 → cfg_done pulse, go to IDLE.
  - Counter reaches LOCK_TIMEOUT with lock still 0 → lock_err pulse; err_cnt+1 if below 255, else held at 255; go to IDLE.
  - If lock and timeout occur in the same cycle, lock wins.
- Back-to-back entries: IDLE→POP costs one cycle. The FIFO is never popped while state != IDLE.
- pllf_flush=1 in any state:
  - Next state is IDLE, with cs_n=1, sck=0, sdo=0, pllf_rd_en=0.
  - No cfg_done or lock_err is issued.
  - pll_chain and err_cnt are retained.
  - Flush has priority over every transition, including a pending POP.
- An entry popped and then aborted by flush is discarded, not retried.
- rst mid-operation: all outputs and state return to reset values on the next edge. err_cnt is cleared.
- pllf_empty is ignored outside IDLE.

Test Plan:
- CLK_DIV=2, SETTLE_CYC=4, push one entry with chain=0x03 and word=96'hA5..A5, pll_lock tied high → rd_en 1 cycle; pll_chain=0x03; 96 sck rising edges; bits captured at those edges equal the 96-bit word; cs_n low for 384 cycles; cfg_done one cycle after SETTLE ends; busy falls with cfg_done.
- LOCK_TIMEOUT=10, pll_lock=0 → lock_err pulses exactly 10 cycles after entering WAIT_LOCK; err_cnt=1; no cfg_done.
- Assert pllf_flush at bit 40 of SHIFT → next cycle cs_n=1, sck=0, busy=0; no pulses; a second queued entry starts only after flush deasserts.
- Three entries queued, lock high → three cfg_done pulses; three rd_en pulses, each issued only from IDLE; chains latched in FIFO order.
- LOCK_TIMEOUT=1, 257 entries with lock low → err_cnt saturates at 255; lock_err pulses 257 times.
- pllf_empty held high for 1000 cycles → pllf_rd_en never asserted; busy=0; then assert rst mid-SHIFT → all outputs at reset values next cycle.

Source files
------------

// File: rtl/pll_cfg_sequencer_if.sv
// ---------------------------------------------------------------------------
// pll_cfg_sequencer_if
// Groups the PLL configuration sequencer's external signals:
//   FIFO side   : pllf_empty, pllf_rd_en, pllf_dout[103:0], pllf_flush
//   Serial side : pll_cs_n, pll_sck, pll_sdo, pll_chain[7:0], pll_lock
//   Status side : busy, cfg_done, lock_err, err_cnt[7:0]
// Modports:
//   master - the sequencer (drives pop, serial port and status)
//   slave  - the environment (FIFO, PLL and API slave)
// ---------------------------------------------------------------------------
interface pll_cfg_sequencer_if;
  logic         pllf_empty;
  logic         pllf_rd_en;
  logic [103:0] pllf_dout;
  logic         pllf_flush;
  logic         pll_cs_n;
  logic         pll_sck;
  logic         pll_sdo;
  logic [7:0]   pll_chain;
  logic         pll_lock;
  logic         busy;
  logic         cfg_done;
  logic         lock_err;
  logic [7:0]   err_cnt;

  modport master (
    input  pllf_empty, pllf_dout, pllf_flush, pll_lock,
    output pllf_rd_en, pll_cs_n, pll_sck, pll_sdo, pll_chain,
           busy, cfg_done, lock_err, err_cnt
  );

  modport slave (
    output pllf_empty, pllf_dout, pllf_flush, pll_lock,
    input  pllf_rd_en, pll_cs_n, pll_sck, pll_sdo, pll_chain,
           busy, cfg_done, lock_err, err_cnt
  );
endinterface

// File: rtl/pll_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// pll_cfg_sequencer
// Pops PLL configuration entries from the config FIFO, shifts the 96-bit
// PLL word MSB first over a 3-wire serial port to the selected chain, then
// waits (with timeout) for the PLL to lock and reports the outcome.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - pll_cfg_sequencer_if.master (FIFO, serial port and status)
// Parameters:
//   CLK_DIV      - clk cycles per sck half-period (1..255)
//   SETTLE_CYC   - clk cycles with cs_n high before lock sampling (>=1)
//   LOCK_TIMEOUT - maximum clk cycles to wait for pll_lock (1..65535)
// ---------------------------------------------------------------------------
module pll_cfg_sequencer #(
  parameter int CLK_DIV      = 8,
  parameter int SETTLE_CYC   = 16,
  parameter int LOCK_TIMEOUT = 4096
) (
  input logic                  clk,
  input logic                  rst,
  pll_cfg_sequencer_if.master  bus
);

  typedef enum logic [2:0] {IDLE, POP, LOAD, SHIFT, SETTLE, WAIT_LOCK} state_t;

  localparam logic [15:0] DIV_LAST     = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);

  state_t        state_q, state_d;
  // One counter serves as sck divider, settle timer and lock timer; it is
  // cleared on every state change that uses it.
  logic [15:0]   cnt_q, cnt_d;
  logic [6:0]    bit_q, bit_d;
  logic [95:0]   shreg_q, shreg_d;
  logic          rd_en_q, rd_en_d;
  logic          cs_n_q, cs_n_d;
  logic          sck_q, sck_d;
  logic          sdo_q, sdo_d;
  logic [7:0]    chain_q, chain_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          cfg_done_q, cfg_done_d;
  logic          lock_err_q, lock_err_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    rd_en_d    = 1'b0;
    cs_n_d     = cs_n_q;
    sck_d      = sck_q;
    sdo_d      = sdo_q;
    chain_d    = chain_q;
    err_cnt_d  = err_cnt_q;
    cfg_done_d = 1'b0;
    lock_err_d = 1'b0;

    if (bus.pllf_flush) begin
      // Abort wins over everything; chain and error count are kept.
      state_d = IDLE;
      cs_n_d  = 1'b1;
      sck_d   = 1'b0;
      sdo_d   = 1'b0;
      cnt_d   = '0;
      bit_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.pllf_empty) begin
            state_d = POP;
            rd_en_d = 1'b1;
          end
        end
        POP: state_d = LOAD;
        LOAD: begin
          shreg_d = bus.pllf_dout[103:8];
          chain_d = bus.pllf_dout[7:0];
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          sdo_d   = bus.pllf_dout[103];
          cnt_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end
        SHIFT: begin
          if (cnt_q == DIV_LAST) begin
            cnt_d = '0;
            if (!sck_q) begin
              sck_d = 1'b1;
            end else begin
              // Falling sck: either finish the frame or present the next bit.
              sck_d = 1'b0;
              if (bit_q == 7'd95) begin
                cs_n_d  = 1'b1;
                sdo_d   = 1'b0;
                state_d = SETTLE;
              end else begin
                bit_d   = bit_q + 7'd1;
                sdo_d   = shreg_q[94];
                shreg_d = {shreg_q[94:0], 1'b0};
              end
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = WAIT_LOCK;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        WAIT_LOCK: begin
          // Lock is tested first so it wins a tie with the timeout.
          if (bus.pll_lock) begin
            cfg_done_d = 1'b1;
            state_d    = IDLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            lock_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      rd_en_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      sck_q      <= 1'b0;
      sdo_q      <= 1'b0;
      chain_q    <= '0;
      err_cnt_q  <= '0;
      cfg_done_q <= 1'b0;
      lock_err_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      rd_en_q    <= rd_en_d;
      cs_n_q     <= cs_n_d;
      sck_q      <= sck_d;
      sdo_q      <= sdo_d;
      chain_q    <= chain_d;
      err_cnt_q  <= err_cnt_d;
      cfg_done_q <= cfg_done_d;
      lock_err_q <= lock_err_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.pllf_rd_en = rd_en_q;
  assign bus.pll_cs_n   = cs_n_q;
  assign bus.pll_sck    = sck_q;
  assign bus.pll_sdo    = sdo_q;
  assign bus.pll_chain  = chain_q;
  assign bus.busy       = busy_q;
  assign bus.cfg_done   = cfg_done_q;
  assign bus.lock_err   = lock_err_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_cfg_sequencer
// Directed bench. Instance A: CLK_DIV=2, SETTLE_CYC=4, LOCK_TIMEOUT=10.
// Instance B: CLK_DIV=1, SETTLE_CYC=1, LOCK_TIMEOUT=1 (error-count saturation).
// Each DUT is fed from a small FIFO model that presents data the cycle after
// a pop.
// ---------------------------------------------------------------------------
module tb_pll_cfg_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pll_cfg_sequencer_if ia ();
  pll_cfg_sequencer_if ib ();

  pll_cfg_sequencer #(.CLK_DIV(2), .SETTLE_CYC(4), .LOCK_TIMEOUT(10))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  pll_cfg_sequencer #(.CLK_DIV(1), .SETTLE_CYC(1), .LOCK_TIMEOUT(1))
    dut_b (.clk(clk), .rst(rst), .bus(ib));

  // FIFO models
  logic [103:0] fa_mem [0:15];
  int fa_wr = 0;
  int fa_rd = 0;
  int fb_wr = 0;
  int fb_rd = 0;
  assign ia.pllf_empty = (fa_wr == fa_rd);
  assign ib.pllf_empty = (fb_wr == fb_rd);
  always @(posedge clk) begin
    if (ia.pllf_rd_en) begin
      ia.pllf_dout <= fa_mem[fa_rd[3:0]];
      fa_rd <= fa_rd + 1;
    end
    if (ib.pllf_rd_en) begin
      ib.pllf_dout <= {96'hFFFF_0000_1234_5678_9ABC_DEF0, 8'h5A};
      fb_rd <= fb_rd + 1;
    end
  end

  // Monitors (sample the values of the cycle that ends at this edge)
  int rd_a = 0, rd_bad_a = 0, done_a = 0, err_a = 0, cslow_a = 0, busy_cyc_a = 0;
  int rise_a = 0, done_b = 0, err_b = 0;
  logic busy_prev_a = 1'b0;
  logic [7:0]  chain_log [0:31];
  logic [95:0] cap_a = '0;

  always @(posedge clk) begin
    if (ia.pllf_rd_en === 1'b1) begin
      rd_a <= rd_a + 1;
      if (busy_prev_a) rd_bad_a <= rd_bad_a + 1;
    end
    busy_prev_a <= (ia.busy === 1'b1);
    if (ia.cfg_done === 1'b1) begin
      chain_log[done_a[4:0]] <= ia.pll_chain;
      done_a <= done_a + 1;
    end
    if (ia.lock_err === 1'b1) err_a <= err_a + 1;
    if (ia.pll_cs_n === 1'b0) cslow_a <= cslow_a + 1;
    if (ia.busy === 1'b1) busy_cyc_a <= busy_cyc_a + 1;
    if (ib.cfg_done === 1'b1) done_b <= done_b + 1;
    if (ib.lock_err === 1'b1) err_b <= err_b + 1;
  end

  always @(posedge ia.pll_sck) begin
    cap_a  <= {cap_a[94:0], ia.pll_sdo};
    rise_a <= rise_a + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sel: 0 = A cfg_done, 1 = A lock_err; returns cycles waited
  task automatic wait_pulse(input int sel, input int maxc, output int n);
    logic seen;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      seen = (sel == 0) ? (ia.cfg_done === 1'b1) : (ia.lock_err === 1'b1);
    end while (!seen && n < maxc);
  endtask

  task automatic push_a(input logic [7:0] chain, input logic [95:0] word);
    fa_mem[fa_wr[3:0]] = {word, chain};
    fa_wr = fa_wr + 1;
  endtask

  localparam logic [95:0] W1 = {12{8'hA5}};
  localparam logic [95:0] W2 = 96'h0123_4567_89AB_CDEF_0123_4567;
  localparam logic [95:0] W3 = 96'hDEAD_BEEF_CAFE_F00D_1357_9BDF;
  localparam logic [95:0] W4 = 96'h8000_0000_0000_0000_0000_0001;
  localparam logic [22:0] RST_VEC = {7'b0100000, 8'h00, 8'h00};

  int n, k, rd0, d0, e0, r0, c0, b0;

  initial begin
    ia.pllf_flush = 1'b0;
    ib.pllf_flush = 1'b0;
    ia.pll_lock   = 1'b1;
    ib.pll_lock   = 1'b0;
    tick(3);
    chk("reset_a", {ia.pllf_rd_en, ia.pll_cs_n, ia.pll_sck, ia.pll_sdo, ia.busy,
                    ia.cfg_done, ia.lock_err, ia.pll_chain, ia.err_cnt}, RST_VEC);
    rst = 1'b0;
    tick(2);
    chk("idle_busy", ia.busy, 1'b0);

    // 1: single entry, lock high
    rd0 = rd_a; d0 = done_a; e0 = err_a; r0 = rise_a; c0 = cslow_a;
    push_a(8'h03, W1);
    wait_pulse(0, 1000, n);
    chk("t1_latency", n, 392);
    chk("t1_busy_with_done", ia.busy, 1'b0);
    tick(1);
    chk("t1_done_one_cycle", ia.cfg_done, 1'b0);
    tick(1);
    chk("t1_rd_pulses", rd_a - rd0, 1);
    chk("t1_sck_rises", rise_a - r0, 96);
    chk("t1_bits", cap_a, W1);
    chk("t1_cs_low", cslow_a - c0, 384);
    chk("t1_chain", ia.pll_chain, 8'h03);
    chk("t1_done_cnt", done_a - d0, 1);
    chk("t1_no_err", err_a - e0, 0);

    // 2: lock timeout
    ia.pll_lock = 1'b0;
    d0 = done_a;
    push_a(8'h11, W2);
    wait_pulse(1, 1000, n);
    chk("t2_latency", n, 401);
    chk("t2_err_cnt", ia.err_cnt, 8'd1);
    chk("t2_busy", ia.busy, 1'b0);
    tick(2);
    chk("t2_no_done", done_a - d0, 0);
    chk("t2_bits", cap_a, W2);
    chk("t2_chain", ia.pll_chain, 8'h11);

    // 3: flush at bit 40, second entry waits for flush release
    ia.pll_lock = 1'b1;
    rd0 = rd_a; d0 = done_a; e0 = err_a; r0 = rise_a;
    push_a(8'h21, W3);
    push_a(8'h22, W4);
    n = 0;
    while ((rise_a - r0) < 41 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t3_reached_bit40", rise_a - r0, 41);
    ia.pllf_flush = 1'b1;
    tick(1);
    chk("t3_flush_outs", {ia.pll_cs_n, ia.pll_sck, ia.pll_sdo, ia.busy, ia.pllf_rd_en},
        5'b10000);
    tick(4);
    chk("t3_busy_held", ia.busy, 1'b0);
    chk("t3_rd_pulses", rd_a - rd0, 1);
    chk("t3_chain_kept", ia.pll_chain, 8'h21);
    chk("t3_errcnt_kept", ia.err_cnt, 8'd1);
    chk("t3_no_pulses", (done_a - d0) + (err_a - e0), 0);
    ia.pllf_flush = 1'b0;
    wait_pulse(0, 1000, n);
    chk("t3_second_latency", n, 392);
    chk("t3_second_chain", ia.pll_chain, 8'h22);
    tick(2);
    chk("t3_second_bits", cap_a, W4);
    chk("t3_rd_total", rd_a - rd0, 2);

    // 4: three back-to-back entries
    rd0 = rd_a; d0 = done_a;
    push_a(8'h31, W1);
    push_a(8'h32, W2);
    push_a(8'h33, W3);
    n = 0; k = 0;
    while (k < 3 && n < 2000) begin
      @(negedge clk);
      n++;
      if (ia.cfg_done === 1'b1) k++;
    end
    chk("t4_total_cycles", n, 1176);
    tick(2);
    chk("t4_done_cnt", done_a - d0, 3);
    chk("t4_rd_cnt", rd_a - rd0, 3);
    chk("t4_rd_only_idle", rd_bad_a, 0);
    chk("t4_chain_order", {chain_log[d0[4:0]], chain_log[d0[4:0] + 5'd1],
                           chain_log[d0[4:0] + 5'd2]}, 24'h313233);

    // B: 257 timeouts, error count saturates
    fb_wr = 257;
    n = 0; k = 0;
    while (k < 255 && n < 60000) begin
      @(negedge clk);
      n++;
      if (ib.lock_err === 1'b1) k++;
    end
    chk("b_255th_cycle", n, 255 * 197);
    chk("b_errcnt_255", ib.err_cnt, 8'd255);
    while (k < 257 && n < 60000) begin
      @(negedge clk);
      n++;
      if (ib.lock_err === 1'b1) k++;
    end
    chk("b_257th_cycle", n, 257 * 197);
    chk("b_errcnt_sat", ib.err_cnt, 8'd255);
    tick(2);
    chk("b_err_pulses", err_b, 257);
    chk("b_no_done", done_b, 0);
    chk("b_chain", ib.pll_chain, 8'h5A);

    // 5: empty FIFO for 1000 cycles, then reset mid-SHIFT
    rd0 = rd_a; b0 = busy_cyc_a;
    tick(1000);
    chk("t5_no_rd", rd_a - rd0, 0);
    chk("t5_no_busy", busy_cyc_a - b0, 0);
    push_a(8'h44, W2);
    tick(100);
    chk("t5_in_shift", {ia.busy, ia.pll_cs_n}, 2'b10);
    rst = 1'b1;
    tick(1);
    chk("t5_reset_a", {ia.pllf_rd_en, ia.pll_cs_n, ia.pll_sck, ia.pll_sdo, ia.busy,
                       ia.cfg_done, ia.lock_err, ia.pll_chain, ia.err_cnt}, RST_VEC);
    chk("t5_reset_b_errcnt", ib.err_cnt, 8'd0);
    rst = 1'b0;
    tick(3);
    chk("t5_idle_after_rst", ia.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
